// File: rtl/coef_bank.sv
// -----------------------------------------------------------------------------
// coef_bank
//   Double-buffered biquad coefficient store. A host writes coefficients one
//   at a time into a shadow set. A commit copies the complete shadow set into
//   the active set in a single edge, so the downstream filter never sees a
//   mix of old and new coefficients.
//
// Ports
//   sample_clock    sole clock, rising edge
//   reset           asynchronous, active-low
//   wr_valid/ready  host write handshake
//   wr_addr         0=b0 1=b1 2=b2 3=a0 4=a1 5=a2 (6,7 invalid)
//   wr_data         value written to the selected shadow register
//   commit          request shadow -> active transfer
//   err_clr         clears the sticky error flags
//   b0..a2          active coefficients (registered)
//   loaded_mask     shadow registers written since the last apply
//   applied         one-cycle pulse after the active set changes
//   err_addr        sticky: accepted write to an invalid address
//   err_incomplete  sticky: commit rejected because the set was incomplete
// -----------------------------------------------------------------------------
module coef_bank #(
    parameter int                      SAMPLE_WIDTH = 24,
    parameter logic [SAMPLE_WIDTH-1:0] COEF_ONE     = 24'h000001
) (
    input  logic                    sample_clock,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [2:0]              wr_addr,
    input  logic [SAMPLE_WIDTH-1:0] wr_data,
    input  logic                    commit,
    input  logic                    err_clr,
    output logic [SAMPLE_WIDTH-1:0] b0,
    output logic [SAMPLE_WIDTH-1:0] b1,
    output logic [SAMPLE_WIDTH-1:0] b2,
    output logic [SAMPLE_WIDTH-1:0] a0,
    output logic [SAMPLE_WIDTH-1:0] a1,
    output logic [SAMPLE_WIDTH-1:0] a2,
    output logic [5:0]              loaded_mask,
    output logic                    applied,
    output logic                    err_addr,
    output logic                    err_incomplete
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              mask_q, mask_d;
    logic                    applied_q, applied_d;
    logic                    err_addr_q, err_addr_d;
    logic                    err_inc_q, err_inc_d;
    logic [SAMPLE_WIDTH-1:0] shadow_q [6];
    logic [SAMPLE_WIDTH-1:0] shadow_d [6];
    logic [SAMPLE_WIDTH-1:0] active_q [6];
    logic [SAMPLE_WIDTH-1:0] active_d [6];

    logic       wr_acc;
    logic       addr_ok;
    logic [5:0] wr_bit;
    logic [5:0] eff_mask;
    logic       err_addr_set;
    logic       err_inc_set;

    assign wr_ready = (state_q != ST_APPLY);
    assign wr_acc   = wr_valid & wr_ready;
    assign addr_ok  = (wr_addr <= 3'd5);
    // One-hot of the shadow register written this cycle (zero if none).
    assign wr_bit   = (wr_acc & addr_ok) ? (6'b000001 << wr_addr) : 6'b000000;
    // A write landing on the same edge as commit counts toward completeness.
    assign eff_mask = mask_q | wr_bit;

    always_comb begin
        state_d      = state_q;
        mask_d       = eff_mask;
        applied_d    = 1'b0;
        err_addr_set = wr_acc & ~addr_ok;
        err_inc_set  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            shadow_d[i] = wr_bit[i] ? wr_data : shadow_q[i];
            active_d[i] = active_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                // commit with an empty mask is ignored
                if (wr_bit != 6'b000000) state_d = ST_LOADING;
            end
            ST_LOADING: begin
                if (commit) begin
                    if (eff_mask == 6'b111111) state_d = ST_APPLY;
                    else                       err_inc_set = 1'b1;
                end
            end
            ST_APPLY: begin
                // wr_ready is low here, so no write can race the transfer
                for (int i = 0; i < 6; i++) active_d[i] = shadow_q[i];
                mask_d    = 6'b000000;
                applied_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Setting an error wins over clearing it in the same cycle.
        err_addr_d = err_addr_set | (err_addr_q & ~err_clr);
        err_inc_d  = err_inc_set  | (err_inc_q  & ~err_clr);
    end

    always_ff @(posedge sample_clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            mask_q     <= 6'b000000;
            applied_q  <= 1'b0;
            err_addr_q <= 1'b0;
            err_inc_q  <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                // b0 and a0 reset to unity, everything else to zero
                shadow_q[i] <= (i == 0 || i == 3) ? COEF_ONE : '0;
                active_q[i] <= (i == 0 || i == 3) ? COEF_ONE : '0;
            end
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            applied_q  <= applied_d;
            err_addr_q <= err_addr_d;
            err_inc_q  <= err_inc_d;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign b0             = active_q[0];
    assign b1             = active_q[1];
    assign b2             = active_q[2];
    assign a0             = active_q[3];
    assign a1             = active_q[4];
    assign a2             = active_q[5];
    assign loaded_mask    = mask_q;
    assign applied        = applied_q;
    assign err_addr       = err_addr_q;
    assign err_incomplete = err_inc_q;

endmodule

// File: tb/tb_coef_bank.sv
// -----------------------------------------------------------------------------
// tb_coef_bank
//   Directed scenarios followed by random traffic, every cycle compared
//   against a transaction-level model of the coefficient bank.
// -----------------------------------------------------------------------------
module tb_coef_bank;

    localparam int W = 24;

    logic          sample_clock = 1'b0;
    logic          reset        = 1'b0;
    logic          wr_valid     = 1'b0;
    logic          wr_ready;
    logic [2:0]    wr_addr      = 3'd0;
    logic [W-1:0]  wr_data      = '0;
    logic          commit       = 1'b0;
    logic          err_clr      = 1'b0;
    logic [W-1:0]  b0, b1, b2, a0, a1, a2;
    logic [5:0]    loaded_mask;
    logic          applied;
    logic          err_addr;
    logic          err_incomplete;

    coef_bank #(.SAMPLE_WIDTH(W), .COEF_ONE(24'h000001)) dut (
        .sample_clock   (sample_clock),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .err_clr        (err_clr),
        .b0             (b0),
        .b1             (b1),
        .b2             (b2),
        .a0             (a0),
        .a1             (a1),
        .a2             (a2),
        .loaded_mask    (loaded_mask),
        .applied        (applied),
        .err_addr       (err_addr),
        .err_incomplete (err_incomplete)
    );

    always #5 sample_clock = ~sample_clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Coefficients held as plain arrays; "pending" means a commit was
    // accepted and the transfer happens on the next edge.
    logic [W-1:0] m_sh  [6];
    logic [W-1:0] m_act [6];
    int           m_mask;
    bit           m_pend, m_applied, m_ea, m_ei;

    function automatic void mdl_reset();
        for (int k = 0; k < 6; k++) begin
            m_act[k] = (k == 0 || k == 3) ? 24'h000001 : 24'h000000;
            m_sh[k]  = m_act[k];
        end
        m_mask = 0; m_pend = 0; m_applied = 0; m_ea = 0; m_ei = 0;
    endfunction

    function automatic void mdl_step();
        bit acc, ok, ea_set, ei_set;
        int bitv;
        acc    = wr_valid && !m_pend;
        ok     = (wr_addr <= 3'd5);
        bitv   = (acc && ok) ? (1 << wr_addr) : 0;
        ea_set = acc && !ok;
        ei_set = 0;
        if (m_pend) begin
            for (int k = 0; k < 6; k++) m_act[k] = m_sh[k];
            m_mask    = 0;
            m_pend    = 0;
            m_applied = 1;
        end else begin
            m_applied = 0;
            if (commit && m_mask != 0) begin
                if ((m_mask | bitv) == 63) m_pend = 1;
                else                       ei_set = 1;
            end
            if (bitv != 0) begin
                m_sh[wr_addr] = wr_data;
                m_mask        = m_mask | bitv;
            end
        end
        m_ea = ea_set || (m_ea && !err_clr);
        m_ei = ei_set || (m_ei && !err_clr);
    endfunction

    task automatic compare_all();
        logic [5:0] em;
        em = m_mask[5:0];
        chk("b0", b0, m_act[0]);
        chk("b1", b1, m_act[1]);
        chk("b2", b2, m_act[2]);
        chk("a0", a0, m_act[3]);
        chk("a1", a1, m_act[4]);
        chk("a2", a2, m_act[5]);
        chk("loaded_mask", loaded_mask, em);
        chk("applied", applied, m_applied);
        chk("err_addr", err_addr, m_ea);
        chk("err_incomplete", err_incomplete, m_ei);
        chk("wr_ready", wr_ready, !m_pend);
    endtask

    // One clock: model advances at the edge, DUT is sampled on the falling edge.
    task automatic tick();
        @(posedge sample_clock);
        if (reset) mdl_step();
        else       mdl_reset();
        @(negedge sample_clock);
        $display("cyc rst_n=%0d wv=%0d addr=%0d data=%06h cm=%0d clr=%0d | mask=%02h rdy=%0d app=%0d ea=%0d ei=%0d b0=%06h",
                 reset, wr_valid, wr_addr, wr_data, commit, err_clr,
                 loaded_mask, wr_ready, applied, err_addr, err_incomplete, b0);
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [2:0] a, input logic [W-1:0] d,
                         input bit c, input bit clr);
        wr_valid = v; wr_addr = a; wr_data = d; commit = c; err_clr = clr;
        tick();
        wr_valid = 0; commit = 0; err_clr = 0;
    endtask

    logic [W-1:0] dval;

    initial begin
        mdl_reset();
        tick();
        reset = 1'b1;
        tick();
        // release state, constants straight from the requirements
        chk("rst_b0", b0, 24'h000001);
        chk("rst_a0", a0, 24'h000001);
        chk("rst_b1", b1, 24'h000000);
        chk("rst_mask", loaded_mask, 6'h00);
        chk("rst_ready", wr_ready, 1'b1);

        // full load and apply
        for (int k = 0; k < 6; k++) begin
            dval = 24'h100000 * (k + 1);
            drive(1, 3'(k), dval, 0, 0);
        end
        chk("full_mask", loaded_mask, 6'h3F);
        drive(0, 3'd0, '0, 1, 0);              // commit at edge N
        chk("apply_ready_low", wr_ready, 1'b0);
        chk("apply_b1_old", b1, 24'h000000);
        tick();                                // edge N+1
        chk("apply_b1_new", b1, 24'h200000);
        chk("apply_a2_new", a2, 24'h600000);
        chk("apply_pulse", applied, 1'b1);
        tick();
        chk("apply_pulse_end", applied, 1'b0);
        chk("apply_mask_clr", loaded_mask, 6'h00);

        // incomplete set, then completing write together with commit
        for (int k = 0; k < 5; k++) drive(1, 3'(k), 24'h0A0000 + 24'(k), 0, 0);
        drive(0, 3'd0, '0, 1, 0);
        chk("inc_err", err_incomplete, 1'b1);
        chk("inc_b0_kept", b0, 24'h100000);
        chk("inc_mask_kept", loaded_mask, 6'h1F);
        drive(1, 3'd5, 24'h0A0005, 1, 0);
        tick();
        chk("inc_a2_applied", a2, 24'h0A0005);
        drive(0, 3'd0, '0, 0, 1);
        chk("inc_err_clr", err_incomplete, 1'b0);

        // invalid address
        drive(1, 3'd7, 24'hABCDEF, 0, 0);
        chk("addr_err", err_addr, 1'b1);
        chk("addr_mask", loaded_mask, 6'h00);
        drive(0, 3'd0, '0, 0, 1);
        chk("addr_err_clr", err_addr, 1'b0);

        // commit in IDLE, then commit/write during APPLY
        drive(0, 3'd0, '0, 1, 0);
        for (int k = 0; k < 6; k++) drive(1, 3'(k), 24'h00C000 + 24'(k), 0, 0);
        drive(0, 3'd0, '0, 1, 0);
        drive(1, 3'd2, 24'h777777, 1, 0);      // lands in APPLY, must be dropped
        chk("apply_ignore_b2", b2, 24'h00C002);
        tick();
        chk("apply_ignore_flags", {err_addr, err_incomplete, applied}, 3'b000);

        // reset during APPLY aborts the transfer
        for (int k = 0; k < 6; k++) drive(1, 3'(k), 24'h0D0000 + 24'(k), 0, 0);
        wr_valid = 0; commit = 1;
        tick();                                // commit at edge N
        commit = 0;
        reset  = 1'b0;
        mdl_reset();
        #1;
        compare_all();
        chk("abort_b0", b0, 24'h000001);
        tick();
        reset = 1'b1;
        tick();
        chk("abort_no_pulse", applied, 1'b0);
        chk("abort_b1", b1, 24'h000000);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                mdl_reset();
                tick();
                reset = 1'b1;
            end
            wr_valid = ($urandom_range(0, 9) < 6);
            wr_addr  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5))
                                                   : 3'($urandom_range(6, 7));
            wr_data  = W'($urandom);
            commit   = ($urandom_range(0, 3) == 0);
            err_clr  = ($urandom_range(0, 9) == 0);
            tick();
        end
        wr_valid = 0; commit = 0; err_clr = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
